dca_serial_rx: RTL and testbench



---
 rtl/dca_serial_rx_if.sv | 29 ++
 rtl/dca_serial_rx.sv | 149 ++++++++++++++
 tb/tb_dca_serial_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dca_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : dca_serial_rx_if
// Brief   : DAC link pins plus recovered channel words, strobes and frame error.
// Revision: 1.0  initial release
// ============================================================================
interface dca_serial_rx_if;
  logic       sclk;
  logic       load_shift;
  logic       di;
  logic [7:0] ch1_out;
  logic [7:0] ch2_out;
  logic       ch1_stb;
  logic       ch2_stb;
  logic       frame_err;

  // master: the serializer side that drives the link and observes the words
  modport master (
    output sclk, load_shift, di,
    input  ch1_out, ch2_out, ch1_stb, ch2_stb, frame_err
  );

  // slave: the receiver
  modport slave (
    input  sclk, load_shift, di,
    output ch1_out, ch2_out, ch1_stb, ch2_stb, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/dca_serial_rx.sv
`default_nettype none
// ============================================================================
// Module  : dca_serial_rx
// Brief   : Oversampling receiver for the two-channel DAC link; 16-bit frames
//           (address byte, data byte) become registered words with strobes.
// Revision: 1.0  initial release
// ============================================================================
module dca_serial_rx #(
  parameter int SYNC_STAGES = 2   // must be 2 or more
) (
  input  wire logic        SYSCLK,
  input  wire logic        RESET_n,
  dca_serial_rx_if.slave   link
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;
  localparam logic [7:0] ADDR_CH1 = 8'h00;
  localparam logic [7:0] ADDR_CH2 = 8'h01;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ls_sync_q;
  logic [SYNC_STAGES-1:0] di_sync_q;
  logic                   sclk_dly_q;
  logic                   ls_dly_q;
  logic [SYNC_STAGES:0]   vld_q;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [7:0]  ch1_q,   ch1_d;
  logic [7:0]  ch2_q,   ch2_d;
  logic        stb1_q,  stb1_d;
  logic        stb2_q,  stb2_d;
  logic        err_q,   err_d;

  logic sclk_s, ls_s, di_s;
  logic sclk_rise, ls_rise, ls_fall, bit_acc, link_ok;

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sclk_sync_q <= '0;
      ls_sync_q   <= '1;
      di_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      ls_dly_q    <= 1'b1;
      vld_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], link.sclk};
      ls_sync_q   <= {ls_sync_q[SYNC_STAGES-2:0],   link.load_shift};
      di_sync_q   <= {di_sync_q[SYNC_STAGES-2:0],   link.di};
      sclk_dly_q  <= sclk_s;
      ls_dly_q    <= ls_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ls_s   = ls_sync_q[SYNC_STAGES-1];
  assign di_s   = di_sync_q[SYNC_STAGES-1];

  // The synchronizers reset to the idle-high LOAD_SHIFT level, so a pin held
  // low across reset release would look like a fresh falling edge. Edges are
  // only trusted once the delayed copy holds a genuine post-reset sample.
  assign link_ok   = vld_q[SYNC_STAGES];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ls_rise   = ls_s & ~ls_dly_q;
  assign ls_fall   = link_ok & ls_dly_q & ~ls_s;
  assign bit_acc   = sclk_rise & ~ls_dly_q;

  always_ff @(posedge SYSCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      stb1_q  <= 1'b0;
      stb2_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ch1_q   <= ch1_d;
      ch2_q   <= ch2_d;
      stb1_q  <= stb1_d;
      stb2_q  <= stb2_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ch1_d   = ch1_q;
    ch2_d   = ch2_q;
    stb1_d  = 1'b0;
    stb2_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ls_fall) state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        // A bit arriving with the closing edge is still part of this frame.
        if (bit_acc) begin
          shift_d = {shift_q[14:0], di_s};
          cnt_d   = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 5'd1;
        end
        if (ls_rise) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        cnt_d = '0;
        if (cnt_q == CNT_FULL && shift_q[15:8] == ADDR_CH1) begin
          ch1_d  = shift_q[7:0];
          stb1_d = 1'b1;
        end else if (cnt_q == CNT_FULL && shift_q[15:8] == ADDR_CH2) begin
          ch2_d  = shift_q[7:0];
          stb2_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = ls_fall ? ST_SHIFT : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign link.ch1_out   = ch1_q;
  assign link.ch2_out   = ch2_q;
  assign link.ch1_stb   = stb1_q;
  assign link.ch2_stb   = stb2_q;
  assign link.frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dca_serial_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_dca_serial_rx
// Brief   : Directed frame table plus reset-mid-frame and idle-SCLK sequences.
// Revision: 1.0  initial release
// ============================================================================
module tb_dca_serial_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF_SCLK   = 4;   // SYSCLK cycles per SCLK phase
  localparam int FRAME_GAP   = 64;  // SYSCLK cycles after LOAD_SHIFT rises
  localparam int MON_CYCLES  = 8;
  localparam int PULSE_AT    = SYNC_STAGES + 2;  // negedge index after close

  logic SYSCLK;
  logic RESET_n;
  dca_serial_rx_if lnk ();

  dca_serial_rx #(.SYNC_STAGES(SYNC_STAGES)) u_dut (
    .SYSCLK  (SYSCLK),
    .RESET_n (RESET_n),
    .link    (lnk)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;
  int n1 = 0, n2 = 0, ne = 0;

  always @(negedge SYSCLK) begin
    if (lnk.ch1_stb)   n1++;
    if (lnk.ch2_stb)   n2++;
    if (lnk.frame_err) ne++;
  end

  typedef struct {
    int          nbits;
    logic [16:0] bits;
    logic [7:0]  ch1;
    logic [7:0]  ch2;
    int          d1;
    int          d2;
    int          de;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // Shifts n bits MSB-first; when close is set the last SCLK rise and the
  // LOAD_SHIFT rise share the same SYSCLK cycle, as the transmitter does.
  task automatic drive_bits(input int n, input logic [16:0] bits, input bit close);
    for (int i = 0; i < n; i++) begin
      lnk.di   = bits[n-1-i];
      lnk.sclk = 1'b0;
      tick(HALF_SCLK);
      lnk.sclk = 1'b1;
      if (close && i == n - 1) lnk.load_shift = 1'b1;
      else tick(HALF_SCLK);
    end
  endtask

  task automatic monitor(output int first);
    first = -1;
    for (int k = 1; k <= MON_CYCLES; k++) begin
      @(negedge SYSCLK);
      if (first < 0 && (lnk.ch1_stb || lnk.ch2_stb || lnk.frame_err)) first = k;
    end
  endtask

  task automatic send_frame(input int n, input logic [16:0] bits, output int first);
    lnk.load_shift = 1'b0;
    drive_bits(n, bits, 1'b1);
    monitor(first);
    lnk.sclk = 1'b0;
    lnk.di   = 1'b1;
    tick(FRAME_GAP - MON_CYCLES);
  endtask

  initial begin
    int first, b1, b2, be;

    vecs[0] = '{16, 17'h000A5, 8'hA5, 8'h00, 1, 0, 0};  // CH1 frame
    vecs[1] = '{16, 17'h0003C, 8'h3C, 8'h00, 1, 0, 0};  // back-to-back CH1
    vecs[2] = '{16, 17'h001C3, 8'h3C, 8'hC3, 0, 1, 0};  // back-to-back CH2
    vecs[3] = '{15, 17'h000FF, 8'h3C, 8'hC3, 0, 0, 1};  // 15 bits of 0x01FF
    vecs[4] = '{17, 17'h100AA, 8'h3C, 8'hC3, 0, 0, 1};  // 17 bits, last 16 look valid
    vecs[5] = '{16, 17'h00255, 8'h3C, 8'hC3, 0, 0, 1};  // bad address 0x02

    RESET_n        = 1'b0;
    lnk.sclk       = 1'b0;
    lnk.load_shift = 1'b1;
    lnk.di         = 1'b1;
    tick(4);
    check("reset_ch1_out",   32'(lnk.ch1_out),   32'h00);
    check("reset_ch2_out",   32'(lnk.ch2_out),   32'h00);
    check("reset_ch1_stb",   32'(lnk.ch1_stb),   32'h0);
    check("reset_ch2_stb",   32'(lnk.ch2_stb),   32'h0);
    check("reset_frame_err", 32'(lnk.frame_err), 32'h0);
    RESET_n = 1'b1;
    tick(8);

    for (int i = 0; i < 6; i++) begin
      b1 = n1; b2 = n2; be = ne;
      send_frame(vecs[i].nbits, vecs[i].bits, first);
      check($sformatf("row%0d_ch1_out", i), 32'(lnk.ch1_out), 32'(vecs[i].ch1));
      check($sformatf("row%0d_ch2_out", i), 32'(lnk.ch2_out), 32'(vecs[i].ch2));
      check($sformatf("row%0d_ch1_stb_count", i), 32'(n1 - b1), 32'(vecs[i].d1));
      check($sformatf("row%0d_ch2_stb_count", i), 32'(n2 - b2), 32'(vecs[i].d2));
      check($sformatf("row%0d_err_count", i),     32'(ne - be), 32'(vecs[i].de));
      check($sformatf("row%0d_pulse_cycle", i),   32'(first),   32'(PULSE_AT));
    end

    // Reset after 8 bits of CH1 0x77, released with LOAD_SHIFT still low.
    lnk.load_shift = 1'b0;
    drive_bits(8, 17'h00000, 1'b0);
    RESET_n = 1'b0;
    tick(3);
    check("midreset_ch1_async_clear", 32'(lnk.ch1_out), 32'h00);
    RESET_n = 1'b1;
    b1 = n1; b2 = n2; be = ne;
    drive_bits(8, 17'h00077, 1'b1);
    monitor(first);
    lnk.sclk = 1'b0;
    lnk.di   = 1'b1;
    tick(FRAME_GAP - MON_CYCLES);
    check("midreset_ch1_out",   32'(lnk.ch1_out), 32'h00);
    check("midreset_ch2_out",   32'(lnk.ch2_out), 32'h00);
    check("midreset_pulses",    32'((n1 - b1) + (n2 - b2) + (ne - be)), 32'd0);

    b1 = n1; b2 = n2; be = ne;
    send_frame(16, 17'h00011, first);
    check("after_reset_ch1_out", 32'(lnk.ch1_out), 32'h11);
    check("after_reset_ch1_stb", 32'(n1 - b1), 32'd1);
    check("after_reset_err",     32'(ne - be), 32'd0);

    // SCLK toggling outside a frame must be ignored.
    b1 = n1; b2 = n2; be = ne;
    lnk.di = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lnk.sclk = 1'b1;
      tick(HALF_SCLK);
      lnk.sclk = 1'b0;
      tick(HALF_SCLK);
    end
    lnk.di = 1'b1;
    tick(8);
    check("idle_sclk_ch1_out", 32'(lnk.ch1_out), 32'h11);
    check("idle_sclk_ch2_out", 32'(lnk.ch2_out), 32'h00);
    check("idle_sclk_pulses",  32'((n1 - b1) + (n2 - b2) + (ne - be)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
